cond_unit: RTL and testbench
============================

# cond_unit

Condition and flag unit for the single-cycle ARM datapath, directly downstream of the ALU. It holds the architectural N/Z/C/V flags, evaluates the instruction condition field, and gates PC, register-file and memory writes. It returns the stored C flag to the ALU for ADC/SBC/RSC. A two-state FSM stalls the core while a multi-cycle multiply/divide unit completes, so flags and writes commit only on the instruction's retiring cycle.

## Interface
Parameters: none.

Ports (name, direction, width, meaning):
- CLK  in  1  single clock, rising edge
- RESET  in  1  asynchronous, active-high reset
- Cond  in  4  instruction condition field, Instr[31:28]
- ALUFlags  in  4  {N,Z,C,V} from the ALU, current cycle
- FlagW  in  2  [1] updates N,Z; [0] updates C,V
- PCS  in  1  decoder: instruction writes PC
- RegW  in  1  decoder: instruction writes register file
- NoWrite  in  1  decoder: compare/test, suppress register write
- MemW  in  1  decoder: store
- MCycleS  in  1  decoder: instruction is multi-cycle (MUL/DIV)
- MCycleBusy  in  1  multi-cycle unit busy
- PCSrc  out  1  gated PC write
- RegWrite  out  1  gated register write
- MemWrite  out  1  gated memory write
- MStart  out  1  one-cycle start pulse to the multi-cycle unit
- Stall  out  1  hold PC and instruction
- Carry  out  1  stored C flag, to ALU Carry input
- CondEx  out  1  condition passed, for debug and LEDs

## Operation
- Flags register {N,Z,C,V} resets to 0000. `Carry` equals the stored C.
- CondEx is a combinational function of Cond and the stored flags:
  - EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V
  - HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V)
  - AL (1110) and 1111 are always 1.
- Commit is the cycle in which an instruction retires:
  - IDLE with MCycleS=0 or CondEx=0, or
  - WAIT with MCycleBusy=0.
- On a commit edge with CondEx=1:
  - FlagW[1] loads N,Z from ALUFlags.
  - FlagW[0] loads C,V from ALUFlags.
- Flags never change when CondEx=0 or Stall=1.
- Write gating:
  - PCSrc = PCS & CondEx & !Stall
  - RegWrite = RegW & CondEx & !NoWrite & !Stall
  - MemWrite = MemW & CondEx & !Stall
- FSM states IDLE and WAIT; reset state is IDLE.
  - IDLE, MCycleS & CondEx: MStart=1, Stall=1, next state WAIT.
  - IDLE, otherwise: stay in IDLE, Stall=0.
  - WAIT, MCycleBusy=1: Stall=1, stay in WAIT.
  - WAIT, MCycleBusy=0: Stall=0, writes and flags commit, next state IDLE.
  - MStart=0 in WAIT.
- A failed-condition multi-cycle instruction is a one-cycle no-op: no MStart, no stall.
- Cond is held stable during WAIT, because Stall freezes the PC. CondEx therefore stays valid while waiting.

## Timing
- Reset values: all flags 0, state IDLE, Stall=0, MStart=0, Carry=0.
- PCSrc, RegWrite, MemWrite and CondEx then follow the combinational rules, with flags at 0.
- RESET is asynchronous. Asserting it in WAIT returns the FSM to IDLE immediately, clears Stall, and clears the flags.
- Flag updates become visible at Carry and CondEx one cycle after the commit edge. A flag-setting instruction followed by a conditional instruction resolves correctly with no bypass, since the core is single-cycle.
- Multi-cycle handshake contract: the multi-cycle unit raises MCycleBusy in the cycle after MStart and holds it until the result is valid.
- Multi-cycle latency is 1 start cycle, plus the busy cycles, plus 1 commit cycle. Stall is high in all cycles except the commit cycle.
- Back-to-back multi-cycle instructions: the commit cycle returns to IDLE, and the next instruction's MStart is asserted the following cycle.

## Structure
- Shared package `arm_defs` holds:
  - condition code constants (COND_EQ … COND_AL, COND_UNC)
  - flag bit indices (FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0)
  - FSM state encodings (ST_IDLE, ST_WAIT)
- One sub-module: `cond_check`. It is purely combinational (Cond, flags → CondEx) and reusable by the pipelined core.
- The flags register and FSM live in `cond_unit`.

## Test plan
- **Reset:** RESET=1 mid-sequence, then release → Carry=0, Stall=0, state IDLE; Cond=0000 (EQ) gives CondEx=0.
- **Compare then branch:** CMP with ALUFlags=0100 and FlagW=11, then Cond=0000 with PCS=1 → next cycle CondEx=1, PCSrc=1. With Cond=0001, PCSrc=0.
- **Partial flag write:** flags=1111, FlagW=10, ALUFlags=0000 → flags become 0011, Carry stays 1.
- **Failed condition:** Cond=0000 with Z=0, RegW=MemW=1, FlagW=11 → RegWrite=MemWrite=0 and flags unchanged. NoWrite=1 with AL also gives RegWrite=0.
- **Multi-cycle:** MCycleS=1, AL, MCycleBusy high for 4 cycles → MStart pulses in cycle 0, Stall=1 for cycles 0–4, RegWrite=1 only in cycle 5, then IDLE.
- **Reset during WAIT:** RESET asserted in WAIT with Busy=1 → Stall drops asynchronously and no RegWrite is issued.

Source files
------------

// File: rtl/arm_defs_pkg.sv
// Shared ARM datapath definitions: condition codes, flag bit positions, FSM states.
// No logic; imported by the condition unit and its checker.
// Reusable by the pipelined core.
package arm_defs;

    localparam logic [3:0] COND_EQ  = 4'b0000;
    localparam logic [3:0] COND_NE  = 4'b0001;
    localparam logic [3:0] COND_CS  = 4'b0010;
    localparam logic [3:0] COND_CC  = 4'b0011;
    localparam logic [3:0] COND_MI  = 4'b0100;
    localparam logic [3:0] COND_PL  = 4'b0101;
    localparam logic [3:0] COND_VS  = 4'b0110;
    localparam logic [3:0] COND_VC  = 4'b0111;
    localparam logic [3:0] COND_HI  = 4'b1000;
    localparam logic [3:0] COND_LS  = 4'b1001;
    localparam logic [3:0] COND_GE  = 4'b1010;
    localparam logic [3:0] COND_LT  = 4'b1011;
    localparam logic [3:0] COND_GT  = 4'b1100;
    localparam logic [3:0] COND_LE  = 4'b1101;
    localparam logic [3:0] COND_AL  = 4'b1110;
    localparam logic [3:0] COND_UNC = 4'b1111;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/cond_check.sv
// Evaluates an ARM condition field against the stored {N,Z,C,V} flags.
// Latency: combinational.
// Backpressure: none.
module cond_check
    import arm_defs::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign n = flags[FLAG_N];
    assign z = flags[FLAG_Z];
    assign c = flags[FLAG_C];
    assign v = flags[FLAG_V];

    always_comb begin
        cond_ex = 1'b1;
        case (cond)
            COND_EQ:  cond_ex = z;
            COND_NE:  cond_ex = !z;
            COND_CS:  cond_ex = c;
            COND_CC:  cond_ex = !c;
            COND_MI:  cond_ex = n;
            COND_PL:  cond_ex = !n;
            COND_VS:  cond_ex = v;
            COND_VC:  cond_ex = !v;
            COND_HI:  cond_ex = c && !z;
            COND_LS:  cond_ex = !c || z;
            COND_GE:  cond_ex = (n == v);
            COND_LT:  cond_ex = (n != v);
            COND_GT:  cond_ex = !z && (n == v);
            COND_LE:  cond_ex = z || (n != v);
            COND_AL:  cond_ex = 1'b1;
            COND_UNC: cond_ex = 1'b1;
            default:  cond_ex = 1'b1;
        endcase
    end

endmodule

// File: rtl/cond_unit.sv
// Flags register, condition evaluation, write gating and multi-cycle stall FSM.
// Latency: gating is combinational; flag updates visible one cycle after commit.
// Backpressure: Stall holds the core from MStart until MCycleBusy falls.
module cond_unit
    import arm_defs::*;
(
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] Cond,
    input  logic [3:0] ALUFlags,
    input  logic [1:0] FlagW,
    input  logic       PCS,
    input  logic       RegW,
    input  logic       NoWrite,
    input  logic       MemW,
    input  logic       MCycleS,
    input  logic       MCycleBusy,
    output logic       PCSrc,
    output logic       RegWrite,
    output logic       MemWrite,
    output logic       MStart,
    output logic       Stall,
    output logic       Carry,
    output logic       CondEx
);

    state_t     state, state_nxt;
    logic [3:0] flags;
    logic       commit;

    cond_check u_cond_check (
        .cond    (Cond),
        .flags   (flags),
        .cond_ex (CondEx)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        MStart    = 1'b0;
        Stall     = 1'b0;
        commit    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (MCycleS && CondEx) begin
                    MStart    = 1'b1;
                    Stall     = 1'b1;
                    state_nxt = ST_WAIT;
                end else begin
                    commit = 1'b1;
                end
            end
            ST_WAIT: begin
                if (MCycleBusy) begin
                    Stall = 1'b1;
                end else begin
                    commit    = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        // Reset forces the quiescent handshake even before the state register settles.
        if (RESET) begin
            MStart = 1'b0;
            Stall  = 1'b0;
            commit = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            flags <= 4'b0000;
        end else if (commit && CondEx) begin
            if (FlagW[1]) begin
                flags[FLAG_N] <= ALUFlags[FLAG_N];
                flags[FLAG_Z] <= ALUFlags[FLAG_Z];
            end
            if (FlagW[0]) begin
                flags[FLAG_C] <= ALUFlags[FLAG_C];
                flags[FLAG_V] <= ALUFlags[FLAG_V];
            end
        end
    end

    assign Carry    = flags[FLAG_C];
    assign PCSrc    = PCS && CondEx && !Stall;
    assign RegWrite = RegW && CondEx && !NoWrite && !Stall;
    assign MemWrite = MemW && CondEx && !Stall;

endmodule

// File: tb/tb_cond_unit.sv
// Directed-vector bench for cond_unit with a queue scoreboard and negedge monitor.
module tb_cond_unit;

    logic       CLK = 1'b0;
    logic       RESET = 1'b1;
    logic [3:0] Cond = 4'b0000;
    logic [3:0] ALUFlags = 4'b0000;
    logic [1:0] FlagW = 2'b00;
    logic       PCS = 1'b0;
    logic       RegW = 1'b0;
    logic       NoWrite = 1'b0;
    logic       MemW = 1'b0;
    logic       MCycleS = 1'b0;
    logic       MCycleBusy = 1'b0;
    logic       PCSrc, RegWrite, MemWrite, MStart, Stall, Carry, CondEx;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        string      name;
        logic [6:0] exp;
    } exp_t;

    exp_t sb [$];

    always #5 CLK = ~CLK;

    cond_unit dut (
        .CLK        (CLK),
        .RESET      (RESET),
        .Cond       (Cond),
        .ALUFlags   (ALUFlags),
        .FlagW      (FlagW),
        .PCS        (PCS),
        .RegW       (RegW),
        .NoWrite    (NoWrite),
        .MemW       (MemW),
        .MCycleS    (MCycleS),
        .MCycleBusy (MCycleBusy),
        .PCSrc      (PCSrc),
        .RegWrite   (RegWrite),
        .MemWrite   (MemWrite),
        .MStart     (MStart),
        .Stall      (Stall),
        .Carry      (Carry),
        .CondEx     (CondEx)
    );

    function automatic string field_name(input int i);
        case (i)
            6:       return "PCSrc";
            5:       return "RegWrite";
            4:       return "MemWrite";
            3:       return "MStart";
            2:       return "Stall";
            1:       return "Carry";
            default: return "CondEx";
        endcase
    endfunction

    // Expected bits: {PCSrc, RegWrite, MemWrite, MStart, Stall, Carry, CondEx}
    task automatic vec(input string nm, input logic rst, input logic [3:0] c,
                       input logic [3:0] af, input logic [1:0] fw,
                       input logic pcs, input logic rw, input logic nw,
                       input logic mw, input logic mcs, input logic busy,
                       input logic [6:0] e);
        exp_t t;
        @(posedge CLK);
        #1;
        RESET      = rst;
        Cond       = c;
        ALUFlags   = af;
        FlagW      = fw;
        PCS        = pcs;
        RegW       = rw;
        NoWrite    = nw;
        MemW       = mw;
        MCycleS    = mcs;
        MCycleBusy = busy;
        t.name = nm;
        t.exp  = e;
        sb.push_back(t);
    endtask

    always @(negedge CLK) begin
        exp_t       t;
        logic [6:0] got;
        if (sb.size() > 0) begin
            t   = sb.pop_front();
            got = {PCSrc, RegWrite, MemWrite, MStart, Stall, Carry, CondEx};
            for (int i = 0; i < 7; i++) begin
                n_cmp++;
                if (got[i] !== t.exp[i]) begin
                    n_err++;
                    $display("FAIL %s.%s got %b want %b", t.name, field_name(i), got[i], t.exp[i]);
                end
            end
        end
    end

    initial begin
        //   name         rst cond     aluf     fw     pcs rw nw mw mcs bsy  expected
        vec("reset",      1, 4'b0000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000000);
        vec("cmp",        0, 4'b1110, 4'b0100, 2'b11, 0, 1, 1, 0, 0, 0, 7'b0000001);
        vec("beq",        0, 4'b0000, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 7'b1000001);
        vec("bne",        0, 4'b0001, 4'b0000, 2'b00, 1, 0, 0, 0, 0, 0, 7'b0000000);
        vec("set_all",    0, 4'b1110, 4'b1111, 2'b11, 0, 1, 0, 0, 0, 0, 7'b0100001);
        vec("partial",    0, 4'b1110, 4'b0000, 2'b10, 0, 0, 0, 0, 0, 0, 7'b0000011);
        // flags now 0011
        vec("hi",         0, 4'b1000, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000011);
        vec("vs",         0, 4'b0110, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000011);
        vec("mi",         0, 4'b0100, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000010);
        vec("fail_cond",  0, 4'b0000, 4'b0100, 2'b11, 0, 1, 0, 1, 0, 0, 7'b0000010);
        vec("lt",         0, 4'b1011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000011);
        vec("nowrite",    0, 4'b1110, 4'b0000, 2'b00, 0, 1, 1, 1, 0, 0, 7'b0010011);
        vec("ge",         0, 4'b1010, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000010);
        vec("gt",         0, 4'b1100, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000010);
        vec("le",         0, 4'b1101, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000011);
        vec("ls",         0, 4'b1001, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000010);
        vec("cc",         0, 4'b0011, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000010);
        vec("pl",         0, 4'b0101, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000011);
        vec("vc",         0, 4'b0111, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000010);
        vec("cs",         0, 4'b0010, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000011);
        vec("ne",         0, 4'b0001, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000011);
        vec("unc",        0, 4'b1111, 4'b0000, 2'b00, 0, 0, 0, 0, 0, 0, 7'b0000011);
        vec("mc_fail",    0, 4'b0000, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0, 7'b0000010);
        // multi-cycle: start, four busy cycles, commit
        vec("mc_c0",      0, 4'b1110, 4'b1000, 2'b11, 0, 1, 0, 0, 1, 0, 7'b0001111);
        for (int k = 1; k <= 4; k++)
            vec($sformatf("mc_c%0d", k),
                          0, 4'b1110, 4'b1000, 2'b11, 0, 1, 0, 0, 1, 1, 7'b0000111);
        vec("mc_c5",      0, 4'b1110, 4'b1000, 2'b11, 0, 1, 0, 0, 1, 0, 7'b0100011);
        // flags now 1000; back-to-back multi-cycle, then reset while waiting
        vec("mul2_go",    0, 4'b0100, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 0, 7'b0001101);
        vec("mul2_wait",  0, 4'b0100, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 1, 7'b0000101);
        vec("rst_wait",   1, 4'b0100, 4'b0000, 2'b00, 0, 1, 0, 0, 1, 1, 7'b0000000);
        vec("post_mi",    0, 4'b0100, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 0, 7'b0000000);
        vec("post_idle",  0, 4'b1110, 4'b0000, 2'b00, 0, 1, 0, 0, 0, 1, 7'b0100001);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge CLK);
        if (sb.size() > 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL drain pending=%0d want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
